titan_clint: RTL and testbench

TITAN_CLINT -- requirements
Module: titan_clint

---
 rtl/titan_clint_pkg.sv | 29 ++
 rtl/titan_clint_tick.sv | 43 ++++
 rtl/titan_clint.sv | 143 ++++++++++++++
 tb/tb_titan_clint.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/titan_clint_pkg.sv
// -----------------------------------------------------------------------------
// titan_clint_pkg
// Shared constants for the TITAN core-local interruptor (CLINT).
//   - Register byte offsets within the 5-bit Wishbone address window.
//   - mtimecmp reset value (all ones, so no timer interrupt after reset).
//   - Lane-merge helper used for byte-enable writes.
// Software headers and testbenches use these same names.
// -----------------------------------------------------------------------------
package titan_clint_pkg;

    localparam logic [4:0] CLINT_OFF_MSIP       = 5'h00;
    localparam logic [4:0] CLINT_OFF_MTIMECMP_L = 5'h04;
    localparam logic [4:0] CLINT_OFF_MTIMECMP_H = 5'h08;
    localparam logic [4:0] CLINT_OFF_MTIME_L    = 5'h0C;
    localparam logic [4:0] CLINT_OFF_MTIME_H    = 5'h10;

    // Highest word index that maps to a register (0x10 >> 2).
    localparam logic [2:0] CLINT_LAST_WORD      = 3'd4;

    localparam logic [63:0] CLINT_MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace the lanes of old_val selected by mask with new_val.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/titan_clint_tick.sv
// -----------------------------------------------------------------------------
// titan_clint_tick
// Free-running prescaler for mtime. Counts 0..TICK_DIV-1 and raises tick for
// one cycle while the count sits at its terminal value, so the mtime register
// advances on the edge that wraps the counter. With TICK_DIV=1 tick is
// permanently high. The first tick edge is TICK_DIV cycles after reset.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset (counter to 0)
//   tick   - one-cycle increment strobe
// -----------------------------------------------------------------------------
module titan_clint_tick #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = (cnt_reg == CNT_MAX);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/titan_clint.sv
// -----------------------------------------------------------------------------
// titan_clint
// Core-local interruptor: 64-bit mtime/mtimecmp timer and machine software
// interrupt bit behind a 32-bit Wishbone slave.
// Ports:
//   clk_i, rst_i       - clock, asynchronous active-high reset
//   wb_cyc_i/stb_i     - bus request
//   wb_we_i            - write enable
//   wb_addr_i[4:0]     - byte address (word-aligned registers 0x00..0x10)
//   wb_dat_i, wb_sel_i - write data and byte-lane enables
//   wb_dat_o           - registered read data (0 unless acking)
//   wb_ack_o/wb_err_o  - single-cycle response, one cycle after the request
//   xint_mtip_o        - registered (mtime >= mtimecmp)
//   xint_msip_o        - MSIP bit 0
// -----------------------------------------------------------------------------
module titan_clint
    import titan_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    logic        tick;

    logic [63:0] mtime_reg,    mtime_next;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic        msip_reg,     msip_next;
    logic        ack_reg,      ack_next;
    logic        err_reg,      err_next;
    logic [31:0] dat_reg,      dat_next;
    logic        mtip_reg;

    logic        req_new;
    logic        addr_legal;
    logic        wr_en;
    logic [31:0] wmask;
    logic [31:0] rdata;

    titan_clint_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick  (tick)
    );

    // A request is only taken when no response is on the bus this cycle;
    // this both avoids answering one request twice and yields the
    // every-second-cycle cadence for a held request.
    assign req_new    = wb_cyc_i & wb_stb_i & ~(ack_reg | err_reg);
    assign addr_legal = (wb_addr_i[1:0] == 2'b00) && (wb_addr_i[4:2] <= CLINT_LAST_WORD);
    assign wr_en      = req_new & addr_legal & wb_we_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{wb_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        rdata = 32'h0;
        case (wb_addr_i)
            CLINT_OFF_MSIP:       rdata = {31'h0, msip_reg};
            CLINT_OFF_MTIMECMP_L: rdata = mtimecmp_reg[31:0];
            CLINT_OFF_MTIMECMP_H: rdata = mtimecmp_reg[63:32];
            CLINT_OFF_MTIME_L:    rdata = mtime_reg[31:0];
            CLINT_OFF_MTIME_H:    rdata = mtime_reg[63:32];
            default:              rdata = 32'h0;
        endcase
    end

    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        msip_next     = msip_reg;

        // A bus write to either mtime half replaces the tick in that cycle.
        if (wr_en && wb_addr_i == CLINT_OFF_MTIME_L) begin
            mtime_next[31:0] = lane_merge(mtime_reg[31:0], wb_dat_i, wmask);
        end else if (wr_en && wb_addr_i == CLINT_OFF_MTIME_H) begin
            mtime_next[63:32] = lane_merge(mtime_reg[63:32], wb_dat_i, wmask);
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end

        if (wr_en && wb_addr_i == CLINT_OFF_MTIMECMP_L) begin
            mtimecmp_next[31:0] = lane_merge(mtimecmp_reg[31:0], wb_dat_i, wmask);
        end
        if (wr_en && wb_addr_i == CLINT_OFF_MTIMECMP_H) begin
            mtimecmp_next[63:32] = lane_merge(mtimecmp_reg[63:32], wb_dat_i, wmask);
        end
        if (wr_en && wb_addr_i == CLINT_OFF_MSIP && wb_sel_i[0]) begin
            msip_next = wb_dat_i[0];
        end
    end

    always_comb begin
        ack_next = req_new & addr_legal;
        err_next = req_new & ~addr_legal;
        dat_next = (req_new & addr_legal) ? rdata : 32'h0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_reg    <= 64'h0;
            mtimecmp_reg <= CLINT_MTIMECMP_RST;
            msip_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            dat_reg      <= 32'h0;
            mtip_reg     <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            msip_reg     <= msip_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            dat_reg      <= dat_next;
            // Compare the present register values; one cycle behind any change.
            mtip_reg     <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign wb_ack_o    = ack_reg;
    assign wb_err_o    = err_reg;
    assign wb_dat_o    = dat_reg;
    assign xint_mtip_o = mtip_reg;
    assign xint_msip_o = msip_reg;

endmodule

// File: tb/tb_titan_clint.sv
// -----------------------------------------------------------------------------
// tb_titan_clint
// Two CLINT instances share one bus: dut1 (TICK_DIV=1) and dut4 (TICK_DIV=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_titan_clint;
    import titan_clint_pkg::*;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [4:0]  addr;
    logic [31:0] wdat;
    logic [3:0]  sel;

    logic [31:0] dat1, dat4;
    logic        ack1, err1, mtip1, msip1;
    logic        ack4, err4, mtip4, msip4;

    // values captured at the response edge of the last transaction
    logic [31:0] dat1_s, dat4_s;
    logic        ack1_s, err1_s, mtip1_s, msip1_s;

    int checks_total  = 0;
    int checks_passed = 0;

    titan_clint #(.TICK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1),
        .xint_mtip_o(mtip1), .xint_msip_o(msip1)
    );

    titan_clint #(.TICK_DIV(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_dat_o(dat4), .wb_ack_o(ack4), .wb_err_o(err4),
        .xint_mtip_o(mtip4), .xint_msip_o(msip4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request cycle plus one idle cycle; caller is at a falling edge.
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
        @(negedge clk);
        ack1_s = ack1; err1_s = err1; dat1_s = dat1; dat4_s = dat4;
        mtip1_s = mtip1; msip1_s = msip1;
        $display("bus we=%0d addr=%h wdata=%h sel=%b -> ack=%0d err=%0d rdata1=%h rdata4=%h",
                 w, a, d, s, ack1_s, err1_s, dat1_s, dat4_s);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = 32'h0; sel = 4'h0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = 5'h0; wdat = 32'h0; sel = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack1, 1'b0);
        check("rst_dat", dat1, 32'h0);
        check("rst_mtip", mtip1, 1'b0);
        check("rst_msip", msip1, 1'b0);
        rst = 1'b0;

        // prescaler: 40 idle cycles at TICK_DIV=4
        repeat (40) @(negedge clk);
        bus(1'b0, CLINT_OFF_MTIME_L, 32'h0, 4'hF);
        check("div4_mtime_lo", dat4_s, 32'd10);
        check("div1_mtime_lo", dat1_s, 32'd40);
        check("read_ack", ack1_s, 1'b1);
        bus(1'b0, CLINT_OFF_MTIME_H, 32'h0, 4'hF);
        check("div4_mtime_hi", dat4_s, 32'h0);
        check("idle_dat_zero", dat1, 32'h0);
        check("idle_ack_low", ack1, 1'b0);

        // timer compare: mtime restarts at 0, mtimecmp = 0x20
        bus(1'b1, CLINT_OFF_MTIME_L, 32'h0, 4'hF);
        bus(1'b1, CLINT_OFF_MTIMECMP_H, 32'h0, 4'hF);
        bus(1'b1, CLINT_OFF_MTIMECMP_L, 32'h20, 4'hF);
        for (int k = 5; k <= 40; k++) begin
            check($sformatf("mtip_k%0d", k), mtip1, (k >= 33) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        bus(1'b1, CLINT_OFF_MTIMECMP_L, 32'hFFFF_FFFF, 4'hF);
        check("mtip_hold_at_ack", mtip1_s, 1'b1);
        check("mtip_drop", mtip1, 1'b0);

        // 64-bit wrap
        bus(1'b1, CLINT_OFF_MTIME_H, 32'hFFFF_FFFF, 4'hF);
        bus(1'b1, CLINT_OFF_MTIME_L, 32'hFFFF_FFFF, 4'hF);
        bus(1'b0, CLINT_OFF_MTIME_L, 32'h0, 4'hF);
        check("wrap_lo", dat1_s, 32'h0);
        bus(1'b0, CLINT_OFF_MTIME_H, 32'h0, 4'hF);
        check("wrap_hi", dat1_s, 32'h0);

        // carry low -> high
        bus(1'b1, CLINT_OFF_MTIME_H, 32'h0, 4'hF);
        bus(1'b1, CLINT_OFF_MTIME_L, 32'hFFFF_FFFF, 4'hF);
        bus(1'b0, CLINT_OFF_MTIME_H, 32'h0, 4'hF);
        check("carry_hi", dat1_s, 32'h1);
        bus(1'b0, CLINT_OFF_MTIME_L, 32'h0, 4'hF);
        check("carry_lo", dat1_s, 32'h2);

        // MSIP and byte lanes
        bus(1'b1, CLINT_OFF_MSIP, 32'h1, 4'b0001);
        check("msip_on_ack", msip1_s, 1'b1);
        check("msip_ack", ack1_s, 1'b1);
        bus(1'b1, CLINT_OFF_MSIP, 32'h0, 4'b0000);
        check("msip_sel0_kept", msip1, 1'b1);
        bus(1'b0, CLINT_OFF_MSIP, 32'h0, 4'hF);
        check("msip_read", dat1_s, 32'h1);
        bus(1'b1, CLINT_OFF_MTIMECMP_L, 32'h1234_5678, 4'b0101);
        bus(1'b0, CLINT_OFF_MTIMECMP_L, 32'h0, 4'hF);
        check("cmp_lanes", dat1_s, 32'hFF34_FF78);

        // illegal offsets
        bus(1'b1, 5'h14, 32'h0, 4'hF);
        check("err14_err", err1_s, 1'b1);
        check("err14_ack", ack1_s, 1'b0);
        check("err14_pulse", err1, 1'b0);
        bus(1'b1, 5'h06, 32'h0, 4'hF);
        check("err06_err", err1_s, 1'b1);
        check("err06_ack", ack1_s, 1'b0);
        check("err06_dat", dat1_s, 32'h0);
        bus(1'b0, CLINT_OFF_MTIMECMP_L, 32'h0, 4'hF);
        check("err_no_change", dat1_s, 32'hFF34_FF78);

        // held request: answered every second cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = CLINT_OFF_MSIP;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("held_ack%0d", k), ack1, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // reset in the middle of a request
        bus(1'b1, CLINT_OFF_MTIMECMP_H, 32'h0, 4'hF);
        bus(1'b1, CLINT_OFF_MTIMECMP_L, 32'h0, 4'hF);
        bus(1'b1, CLINT_OFF_MTIME_H, 32'h0, 4'hF);
        bus(1'b1, CLINT_OFF_MTIME_L, 32'h1234, 4'hF);
        check("pre_rst_mtip", mtip1, 1'b1);
        check("pre_rst_msip", msip1, 1'b1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = CLINT_OFF_MTIME_L;
        #2 rst = 1'b1;
        #1;
        check("rst_async_ack", ack1, 1'b0);
        check("rst_async_err", err1, 1'b0);
        check("rst_async_dat", dat1, 32'h0);
        check("rst_async_mtip", mtip1, 1'b0);
        check("rst_async_msip", msip1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("no_stale_ack%0d", k), ack1 | err1, 1'b0);
        end
        bus(1'b0, CLINT_OFF_MTIME_L, 32'h0, 4'hF);
        check("post_rst_lo_div1", dat1_s, 32'h2);
        check("post_rst_lo_div4", dat4_s, 32'h0);
        bus(1'b0, CLINT_OFF_MTIME_H, 32'h0, 4'hF);
        check("post_rst_hi", dat1_s, 32'h0);
        bus(1'b0, CLINT_OFF_MTIMECMP_L, 32'h0, 4'hF);
        check("post_rst_cmp_lo", dat1_s, CLINT_MTIMECMP_RST[31:0]);
        bus(1'b0, CLINT_OFF_MTIMECMP_H, 32'h0, 4'hF);
        check("post_rst_cmp_hi", dat1_s, 32'hFFFF_FFFF);
        bus(1'b0, CLINT_OFF_MSIP, 32'h0, 4'hF);
        check("post_rst_msip", dat1_s, 32'h0);
        check("post_rst_mtip", mtip1, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
